ram_file_port_arbiter: RTL and testbench

Time-slot arbiter sharing the single-port register-file RAM between the CPU core and the debug/programming port. It owns the Q1–Q4 instruction-phase counter:
- the core gets Q2 (read) and Q4 (write);
- the debug port gets Q1 and Q3 through a req/ack handshake.

It sits between the RAM file address mux output and the RAM file macro. The core never stalls for debug traffic.

---
 rtl/ram_file_port_arbiter.sv | 105 ++++++++++
 tb/tb_ram_file_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_file_port_arbiter.sv
// Time-slot arbiter sharing the register-file RAM between the core (Q2 read, Q4 write)
// and the debug port (Q1/Q3). Optional macro RAM_ARB_DBG_FULL_BW_EN: all slots go to debug while core_halt=1.
module ram_file_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [1:0]            q_phase,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic                  core_rd_req,
  input  logic                  core_wr_req,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  core_halt,
  input  logic                  dbg_req,
  input  logic                  dbg_wr,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_e;

  phase_e phase_q;
  phase_e phase_d;
  logic   halt_bw;
  logic   dbg_slot;
  logic   dbg_access;
  logic   core_rd_en;
  logic   core_wr_en;
  logic   ack_q;

`ifdef RAM_ARB_DBG_FULL_BW_EN
  assign halt_bw = core_halt;
`else
  logic unused_halt;
  assign unused_halt = core_halt;
  assign halt_bw     = 1'b0;
`endif

  // Phase register: free-running Q1..Q4
  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= Q1;
    else        phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      Q1: phase_d = Q2;
      Q2: phase_d = Q3;
      Q3: phase_d = Q4;
      Q4: phase_d = Q1;
    endcase
  end

  assign q_phase = phase_q;

  // Q1/Q3 are the even phases; a halted core in full-bandwidth builds gives up every slot
  assign dbg_slot   = ~phase_q[0] | halt_bw;
  assign dbg_access = dbg_slot & dbg_req & rst_n;
  assign core_rd_en = (phase_q == Q2) & core_rd_req & ~halt_bw;
  assign core_wr_en = (phase_q == Q4) & core_wr_req & ~halt_bw & rst_n;

  // RAM port mux; idle slots park on the core address/data
  always_comb begin
    ram_addr  = core_addr;
    ram_we    = 1'b0;
    ram_wdata = core_wdata;
    if (dbg_access) begin
      ram_addr  = dbg_addr;
      ram_we    = dbg_wr;
      ram_wdata = dbg_wdata;
    end else if (core_wr_en) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      core_rdata <= DATA_WIDTH'(0);
      dbg_rdata  <= DATA_WIDTH'(0);
    end else begin
      ack_q <= dbg_access;
      if (core_rd_en)              core_rdata <= ram_rdata;
      if (dbg_access && !dbg_wr)   dbg_rdata  <= ram_rdata;
    end
  end

  // A reset arriving in the ack cycle cancels the pulse immediately
  assign dbg_ack = ack_q & rst_n;

endmodule

// File: tb/tb_ram_file_port_arbiter.sv
// Directed self-checking bench for ram_file_port_arbiter with a behavioural 512x8 RAM.
// Honours RAM_ARB_DBG_FULL_BW_EN when defined.
module tb_ram_file_port_arbiter;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    q_phase;
  logic [AW-1:0] core_addr;
  logic          core_rd_req, core_wr_req;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_halt;
  logic          dbg_req, dbg_wr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          load_en;
  logic [DW-1:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_file_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .q_phase(q_phase),
    .core_addr(core_addr), .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_halt(core_halt),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM model: preset contents loaded while load_en is high
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem[9'h020] <= 8'h5A;
      mem[9'h1A4] <= 8'hC3;
      mem[9'h070] <= 8'h3C;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4 && q_phase !== p; i++) tick();
    checks++;
    if (q_phase !== p) begin errors++; $display("FAIL wait_phase: q_phase=%0d required %0d", q_phase, p); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b1;
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h1FF; dbg_wdata = 8'hEE;
    core_wr_req = 1'b1; core_rd_req = 1'b0; core_addr = 9'h010; core_wdata = 8'h33; core_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: ram_we=%b required 0", ram_we); end
      checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: dbg_ack=%b required 0", dbg_ack); end
      checks++; if (q_phase !== 2'd0) begin errors++; $display("FAIL reset_phase: q_phase=%0d required 0", q_phase); end
    end
    checks++; if (core_rdata !== 8'h00 || dbg_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata: core_rdata=%h dbg_rdata=%h required 00 00", core_rdata, dbg_rdata); end
    checks++; if (ram_addr !== 9'h010 || ram_wdata !== 8'h33) begin
      errors++; $display("FAIL reset_mux: ram_addr=%h ram_wdata=%h required 010 33", ram_addr, ram_wdata); end
    rst_n = 1'b1; load_en = 1'b0; dbg_req = 1'b0; core_wr_req = 1'b0;
    #1;
    checks++; if (q_phase !== 2'd0) begin errors++; $display("FAIL release_phase0: q_phase=%0d required 0", q_phase); end
    for (int k = 1; k <= 4; k++) begin
      tick(); #1;
      checks++; if (q_phase !== 2'(k % 4)) begin
        errors++; $display("FAIL release_phase: q_phase=%0d required %0d", q_phase, k % 4); end
    end
  endtask

  task automatic test_core_rmw();
    wait_phase(2'd0);
    core_addr = 9'h020; core_rd_req = 1'b1; core_wr_req = 1'b1; core_wdata = 8'h5B;
    tick(); #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 9'h020) begin
      errors++; $display("FAIL rmw_q2: ram_we=%b ram_addr=%h required 0 020", ram_we, ram_addr); end
    tick(); #1;
    checks++; if (core_rdata !== 8'h5A) begin errors++; $display("FAIL rmw_rdata: core_rdata=%h required 5a", core_rdata); end
    tick(); #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 9'h020 || ram_wdata !== 8'h5B) begin
      errors++; $display("FAIL rmw_q4: we=%b addr=%h wdata=%h required 1 020 5b", ram_we, ram_addr, ram_wdata); end
    tick();
    core_rd_req = 1'b0; core_wr_req = 1'b0;
    #1;
    checks++; if (mem[9'h020] !== 8'h5B) begin errors++; $display("FAIL rmw_mem: mem=%h required 5b", mem[9'h020]); end
  endtask

  task automatic test_dbg_read();
    wait_phase(2'd1);
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 9'h1A4; core_addr = 9'h020;
    #1;
    checks++; if (ram_addr !== 9'h020 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL dbgrd_q2: ram_addr=%h dbg_ack=%b required 020 0", ram_addr, dbg_ack); end
    tick(); #1;
    checks++; if (ram_addr !== 9'h1A4 || ram_we !== 1'b0) begin
      errors++; $display("FAIL dbgrd_q3: ram_addr=%h ram_we=%b required 1a4 0", ram_addr, ram_we); end
    tick(); #1;
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 8'hC3 || ram_we !== 1'b0) begin
      errors++; $display("FAIL dbgrd_ack: ack=%b rdata=%h we=%b required 1 c3 0", dbg_ack, dbg_rdata, ram_we); end
    dbg_req = 1'b0;
    tick(); #1;
    checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 8'hC3) begin
      errors++; $display("FAIL dbgrd_hold: ack=%b rdata=%h required 0 c3", dbg_ack, dbg_rdata); end
  endtask

  task automatic test_dbg_write_core_read();
    wait_phase(2'd2);
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h030; dbg_wdata = 8'h77;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 9'h030 || ram_wdata !== 8'h77) begin
      errors++; $display("FAIL dbgwr_q3: we=%b addr=%h wdata=%h required 1 030 77", ram_we, ram_addr, ram_wdata); end
    tick();
    dbg_req = 1'b0; core_addr = 9'h030; core_rd_req = 1'b1;
    #1;
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dbgwr_ack: dbg_ack=%b required 1", dbg_ack); end
    tick(); tick(); #1;
    checks++; if (ram_addr !== 9'h030 || ram_we !== 1'b0) begin
      errors++; $display("FAIL dbgwr_coreq2: ram_addr=%h ram_we=%b required 030 0", ram_addr, ram_we); end
    tick(); #1;
    checks++; if (core_rdata !== 8'h77) begin errors++; $display("FAIL dbgwr_coreread: core_rdata=%h required 77", core_rdata); end
    core_rd_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int accesses = 0;
    logic [1:0]    ph;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_we;
    wait_phase(2'd0);
    dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h050; dbg_wdata = 8'hAB;
    core_addr = 9'h040; core_wdata = 8'h99; core_wr_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      ph = 2'(c % 4);
      e_addr = ph[0] ? 9'h040 : 9'h050;
      e_wd   = ph[0] ? 8'h99 : 8'hAB;
      e_we   = (ph != 2'd1);
      if (ram_we && ram_addr == 9'h050) accesses++;
      if (dbg_ack) acks++;
      checks++; if (q_phase !== ph || ram_addr !== e_addr || ram_we !== e_we || ram_wdata !== e_wd || dbg_ack !== ph[0]) begin
        errors++; $display("FAIL b2b_cycle%0d: ph=%0d addr=%h we=%b wd=%h ack=%b required %0d %h %b %h %b",
                           c, q_phase, ram_addr, ram_we, ram_wdata, dbg_ack, ph, e_addr, e_we, e_wd, ph[0]); end
      tick();
    end
    dbg_req = 1'b0; core_wr_req = 1'b0;
    #1;
    checks++; if (acks != 4 || accesses != 4 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_count: acks=%0d accesses=%0d ack_now=%b required 4 4 0", acks, accesses, dbg_ack); end
    checks++; if (mem[9'h040] !== 8'h99 || mem[9'h050] !== 8'hAB || dbg_rdata !== 8'hC3) begin
      errors++; $display("FAIL b2b_mem: m40=%h m50=%h dbg_rdata=%h required 99 ab c3", mem[9'h040], mem[9'h050], dbg_rdata); end
  endtask

  task automatic test_reset_mid_ack();
    wait_phase(2'd0);
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 9'h1A4;
    #1;
    checks++; if (ram_addr !== 9'h1A4) begin errors++; $display("FAIL midrst_access: ram_addr=%h required 1a4", ram_addr); end
    tick();
    rst_n = 1'b0; dbg_req = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: dbg_ack=%b required 0", dbg_ack); end
    tick(); #1;
    checks++; if (dbg_ack !== 1'b0 || q_phase !== 2'd0 || dbg_rdata !== 8'h00 || core_rdata !== 8'h00) begin
      errors++; $display("FAIL midrst_state: ack=%b ph=%0d drd=%h crd=%h required 0 0 00 00", dbg_ack, q_phase, dbg_rdata, core_rdata); end
    rst_n = 1'b1;
    tick(); #1;
    checks++; if (dbg_ack !== 1'b0 || q_phase !== 2'd1) begin
      errors++; $display("FAIL midrst_after: ack=%b ph=%0d required 0 1", dbg_ack, q_phase); end
  endtask

  task automatic test_halt();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_we, e_ack;
    wait_phase(2'd0);
    core_halt = 1'b1; dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 9'h060; dbg_wdata = 8'h11;
    core_addr = 9'h070; core_wdata = 8'h22; core_rd_req = 1'b1; core_wr_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef RAM_ARB_DBG_FULL_BW_EN
      e_addr = 9'h060; e_we = 1'b1; e_wd = 8'h11; e_ack = (c != 0);
`else
      e_addr = (c % 2 == 0) ? 9'h060 : 9'h070;
      e_wd   = (c % 2 == 0) ? 8'h11 : 8'h22;
      e_we   = (c != 1);
      e_ack  = (c % 2 == 1);
`endif
      checks++; if (ram_addr !== e_addr || ram_we !== e_we || ram_wdata !== e_wd || dbg_ack !== e_ack) begin
        errors++; $display("FAIL halt_cycle%0d: addr=%h we=%b wd=%h ack=%b required %h %b %h %b",
                           c, ram_addr, ram_we, ram_wdata, dbg_ack, e_addr, e_we, e_wd, e_ack); end
      tick();
    end
    dbg_req = 1'b0; core_rd_req = 1'b0; core_wr_req = 1'b0; core_halt = 1'b0;
    #1;
`ifdef RAM_ARB_DBG_FULL_BW_EN
    checks++; if (dbg_ack !== 1'b1 || mem[9'h070] !== 8'h3C || mem[9'h060] !== 8'h11 || core_rdata !== 8'h00) begin
      errors++; $display("FAIL halt_end: ack=%b m70=%h m60=%h crd=%h required 1 3c 11 00", dbg_ack, mem[9'h070], mem[9'h060], core_rdata); end
`else
    checks++; if (dbg_ack !== 1'b0 || mem[9'h070] !== 8'h22 || mem[9'h060] !== 8'h11 || core_rdata !== 8'h3C) begin
      errors++; $display("FAIL halt_end: ack=%b m70=%h m60=%h crd=%h required 0 22 11 3c", dbg_ack, mem[9'h070], mem[9'h060], core_rdata); end
`endif
  endtask

  initial begin
    test_reset();
    test_core_rmw();
    test_dbg_read();
    test_dbg_write_core_read();
    test_back_to_back();
    test_reset_mid_ack();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
